// File: rtl/branch_stream_gen_if.sv
// branch_stream_gen_if: pattern config, run control, predictor stream and score bus
// master = generator side (drives the branch stream and status), slave = host/predictor side.
interface branch_stream_gen_if #(
  parameter int IDX_W = 4,
  parameter int N_SLOTS = 4,
  parameter int CNT_W = 16,
  localparam int SW = $clog2(N_SLOTS)
);
  logic cfg_we;
  logic [SW-1:0] cfg_slot;
  logic [IDX_W-1:0] cfg_index;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic cfg_rand;
  logic [SW:0] active_slots;
  logic [CNT_W-1:0] num_branches;
  logic start;
  logic prediction;
  logic [IDX_W-1:0] branch_index;
  logic branch_outcome;
  logic branch_valid;
  logic busy;
  logic done;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic last_hit;
  modport master (
    input cfg_we, cfg_slot, cfg_index, cfg_pattern, cfg_len, cfg_rand,
    input active_slots, num_branches, start, prediction,
    output branch_index, branch_outcome, branch_valid, busy, done,
    output total_cnt, miss_cnt, last_hit
  );
  modport slave (
    output cfg_we, cfg_slot, cfg_index, cfg_pattern, cfg_len, cfg_rand,
    output active_slots, num_branches, start, prediction,
    input branch_index, branch_outcome, branch_valid, busy, done,
    input total_cnt, miss_cnt, last_hit
  );
endinterface

// File: rtl/branch_stream_gen.sv
// branch_stream_gen: table-driven branch stream source that scores predictor accuracy
// Ports: clk, reset (sync, active-high), bus (branch_stream_gen_if.master: cfg table
// writes, run control, branch stream out, prediction in, counters out).
// Optional macro BSG_LFSR_EN: per-slot LFSR outcome source (x^8+x^6+x^5+x^4+1, seed 8'hA5).
module branch_stream_gen #(
  parameter int IDX_W = 4,
  parameter int N_SLOTS = 4,
  parameter int CNT_W = 16,
  localparam int SW = $clog2(N_SLOTS)
) (
  input logic clk,
  input logic reset,
  branch_stream_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, SCORE, DONE} state_t;
  state_t state, next;
  logic [IDX_W-1:0] idx [N_SLOTS];
  logic [7:0] pat [N_SLOTS];
  logic [2:0] len [N_SLOTS];
  logic [2:0] pos [N_SLOTS];
  logic [SW-1:0] slot;
  logic [SW:0] nact, slot_inc, act_in;
  logic [CNT_W-1:0] remaining;
  logic [IDX_W-1:0] idx_q;
  logic out_q;
  logic cur_out;
`ifdef BSG_LFSR_EN
  logic rnd [N_SLOTS];
  logic [7:0] lfsr;
  assign cur_out = rnd[slot] ? lfsr[0] : pat[slot][pos[slot]];
`else
  logic unused_rand;
  assign unused_rand = bus.cfg_rand;
  assign cur_out = pat[slot][pos[slot]];
`endif
  assign slot_inc = (SW+1)'(slot) + (SW+1)'(1);
  assign act_in = (bus.active_slots == '0 || bus.active_slots > (SW+1)'(N_SLOTS)) ? (SW+1)'(N_SLOTS) : bus.active_slots;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  // Outside ISSUE the stream outputs replay the last issued values held in idx_q/out_q.
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.start ? ((bus.num_branches == '0) ? DONE : ISSUE) : IDLE;
      ISSUE: next = SCORE;
      SCORE: next = (remaining == CNT_W'(1)) ? DONE : ISSUE;
      default: next = IDLE;
    endcase
    bus.branch_valid = state == ISSUE;
    bus.branch_index = (state == ISSUE) ? idx[slot] : idx_q;
    bus.branch_outcome = (state == ISSUE) ? cur_out : out_q;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        idx[i] <= '0;
        pat[i] <= '0;
        len[i] <= '0;
        pos[i] <= '0;
`ifdef BSG_LFSR_EN
        rnd[i] <= 1'b0;
`endif
      end
`ifdef BSG_LFSR_EN
      lfsr <= 8'hA5;
`endif
      slot <= '0;
      nact <= '0;
      remaining <= '0;
      idx_q <= '0;
      out_q <= 1'b0;
      bus.total_cnt <= '0;
      bus.miss_cnt <= '0;
      bus.last_hit <= 1'b0;
    end else begin
      if (state == IDLE && bus.cfg_we) begin
        idx[bus.cfg_slot] <= bus.cfg_index;
        pat[bus.cfg_slot] <= bus.cfg_pattern;
        len[bus.cfg_slot] <= bus.cfg_len;
        pos[bus.cfg_slot] <= '0;
`ifdef BSG_LFSR_EN
        rnd[bus.cfg_slot] <= bus.cfg_rand;
`endif
      end
      if (state == IDLE && bus.start) begin
        remaining <= bus.num_branches;
        nact <= act_in;
        slot <= '0;
        bus.total_cnt <= '0;
        bus.miss_cnt <= '0;
        bus.last_hit <= 1'b0;
      end
      if (state == ISSUE) begin
        idx_q <= idx[slot];
        out_q <= cur_out;
`ifdef BSG_LFSR_EN
        if (rnd[slot]) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
      end
      if (state == SCORE) begin
        bus.last_hit <= bus.prediction == out_q;
        bus.total_cnt <= (bus.total_cnt == '1) ? bus.total_cnt : bus.total_cnt + CNT_W'(1);
        bus.miss_cnt <= (bus.prediction == out_q || bus.miss_cnt == '1) ? bus.miss_cnt : bus.miss_cnt + CNT_W'(1);
        pos[slot] <= (pos[slot] == len[slot]) ? 3'd0 : pos[slot] + 3'd1;
        slot <= (slot_inc == nact) ? '0 : slot_inc[SW-1:0];
        remaining <= remaining - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_stream_gen.sv
// tb_branch_stream_gen: directed self-checking bench for branch_stream_gen
module tb_branch_stream_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  branch_stream_gen_if bus ();
  branch_stream_gen dut (.clk(clk), .reset(reset), .bus(bus));
  int n_checks = 0;
  int n_pass = 0;
  int n_obs, done_cyc, busy_cyc, done_cnt;
  bit timed_out;
  logic [3:0] obs_idx [64];
  logic obs_out [64];
  int obs_cyc [64];
  localparam logic [3:0] ALT_IDX [8] = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4};
  localparam logic ALT_OUT [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [3:0] PER_IDX [8] = '{4'd3, 4'd4, 4'd9, 4'd12, 4'd3, 4'd4, 4'd9, 4'd12};
  localparam logic PER_OUT [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] s, input logic [3:0] i, input logic [7:0] p, input logic [2:0] l, input logic r);
    bus.cfg_we = 1'b1;
    bus.cfg_slot = s;
    bus.cfg_index = i;
    bus.cfg_pattern = p;
    bus.cfg_len = l;
    bus.cfg_rand = r;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // Pulses start, then records every issued branch until busy drops; cycle 1 is the
  // cycle after the start edge. At cycle poke, start and cfg_we are asserted mid-run.
  task automatic run(input int n, input int act, input int poke);
    n_obs = 0;
    done_cyc = -1;
    busy_cyc = 0;
    done_cnt = 0;
    timed_out = 1'b1;
    bus.num_branches = 16'(n);
    bus.active_slots = 3'(act);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (!bus.busy) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.branch_valid && n_obs < 64) begin
        obs_idx[n_obs] = bus.branch_index;
        obs_out[n_obs] = bus.branch_outcome;
        obs_cyc[n_obs] = c;
        n_obs++;
      end
      busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      bus.start = (c == poke);
      bus.cfg_we = (c == poke);
      tick();
    end
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0h want 0", bus.done); else n_pass++;
    n_checks++; if (bus.branch_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", bus.branch_valid); else n_pass++;
    n_checks++; if (bus.branch_index !== 4'd0) $display("FAIL reset_index got %0h want 0", bus.branch_index); else n_pass++;
    n_checks++; if (bus.branch_outcome !== 1'b0) $display("FAIL reset_outcome got %0h want 0", bus.branch_outcome); else n_pass++;
    n_checks++; if (bus.total_cnt !== 16'd0) $display("FAIL reset_total got %0h want 0", bus.total_cnt); else n_pass++;
    n_checks++; if (bus.miss_cnt !== 16'd0) $display("FAIL reset_miss got %0h want 0", bus.miss_cnt); else n_pass++;
    n_checks++; if (bus.last_hit !== 1'b0) $display("FAIL reset_last_hit got %0h want 0", bus.last_hit); else n_pass++;
  endtask

  task automatic test_zero_length;
    run(0, 1, 0);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL zero_timeout got %0h want 0", timed_out); else n_pass++;
    n_checks++; if (done_cyc !== 1) $display("FAIL zero_done_cycle got %0d want 1", done_cyc); else n_pass++;
    n_checks++; if (busy_cyc !== 1) $display("FAIL zero_busy_cycles got %0d want 1", busy_cyc); else n_pass++;
    n_checks++; if (n_obs !== 0) $display("FAIL zero_valid_count got %0d want 0", n_obs); else n_pass++;
    n_checks++; if (bus.total_cnt !== 16'd0) $display("FAIL zero_total got %0h want 0", bus.total_cnt); else n_pass++;
    n_checks++; if (bus.miss_cnt !== 16'd0) $display("FAIL zero_miss got %0h want 0", bus.miss_cnt); else n_pass++;
  endtask

  task automatic test_alternating;
    write_slot(2'd0, 4'd3, 8'b01, 3'd1, 1'b0);
    write_slot(2'd1, 4'd4, 8'hFF, 3'd0, 1'b0);
    bus.prediction = 1'b1;
    run(8, 2, 0);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL alt_timeout got %0h want 0", timed_out); else n_pass++;
    n_checks++; if (n_obs !== 8) $display("FAIL alt_count got %0d want 8", n_obs); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (obs_idx[k] !== ALT_IDX[k]) $display("FAIL alt_index[%0d] got %0h want %0h", k, obs_idx[k], ALT_IDX[k]); else n_pass++;
      n_checks++; if (obs_out[k] !== ALT_OUT[k]) $display("FAIL alt_outcome[%0d] got %0h want %0h", k, obs_out[k], ALT_OUT[k]); else n_pass++;
    end
    n_checks++; if (bus.total_cnt !== 16'd8) $display("FAIL alt_total got %0d want 8", bus.total_cnt); else n_pass++;
    n_checks++; if (bus.miss_cnt !== 16'd2) $display("FAIL alt_miss got %0d want 2", bus.miss_cnt); else n_pass++;
    n_checks++; if (bus.last_hit !== 1'b1) $display("FAIL alt_last_hit got %0h want 1", bus.last_hit); else n_pass++;
  endtask

  task automatic test_pattern_period;
    write_slot(2'd0, 4'd3, 8'b01, 3'd1, 1'b0);
    write_slot(2'd1, 4'd4, 8'hFF, 3'd0, 1'b0);
    write_slot(2'd2, 4'd9, 8'b1011_0010, 3'd7, 1'b0);
    write_slot(2'd3, 4'd12, 8'b0000_0110, 3'd2, 1'b0);
    bus.prediction = 1'b0;
    run(8, 0, 0);
    n_checks++; if (n_obs !== 8) $display("FAIL per_count got %0d want 8", n_obs); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (obs_idx[k] !== PER_IDX[k]) $display("FAIL per_index[%0d] got %0h want %0h", k, obs_idx[k], PER_IDX[k]); else n_pass++;
      n_checks++; if (obs_out[k] !== PER_OUT[k]) $display("FAIL per_outcome[%0d] got %0h want %0h", k, obs_out[k], PER_OUT[k]); else n_pass++;
    end
    n_checks++; if (bus.miss_cnt !== 16'd5) $display("FAIL per_miss got %0d want 5", bus.miss_cnt); else n_pass++;
    n_checks++; if (bus.last_hit !== 1'b0) $display("FAIL per_last_hit got %0h want 0", bus.last_hit); else n_pass++;
  endtask

  task automatic test_latency;
    write_slot(2'd0, 4'd3, 8'b01, 3'd1, 1'b0);
    bus.prediction = 1'b1;
    run(3, 1, 0);
    n_checks++; if (n_obs !== 3) $display("FAIL lat_count got %0d want 3", n_obs); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (obs_cyc[k] !== 2 * k + 1) $display("FAIL lat_valid_cycle[%0d] got %0d want %0d", k, obs_cyc[k], 2 * k + 1); else n_pass++;
    end
    n_checks++; if (done_cyc !== 7) $display("FAIL lat_done_cycle got %0d want 7", done_cyc); else n_pass++;
    n_checks++; if (busy_cyc !== 7) $display("FAIL lat_busy_cycles got %0d want 7", busy_cyc); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL lat_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (bus.branch_index !== 4'd3 || bus.branch_outcome !== 1'b1) $display("FAIL lat_hold got %0h/%0h want 3/1", bus.branch_index, bus.branch_outcome); else n_pass++;
    n_checks++; if (bus.miss_cnt !== 16'd1) $display("FAIL lat_miss got %0d want 1", bus.miss_cnt); else n_pass++;
  endtask

  task automatic test_ignored_inputs;
    write_slot(2'd0, 4'd3, 8'b10, 3'd1, 1'b0);
    bus.cfg_slot = 2'd0;
    bus.cfg_index = 4'd15;
    bus.cfg_pattern = 8'hFF;
    bus.cfg_len = 3'd0;
    bus.prediction = 1'b0;
    run(4, 1, 3);
    n_checks++; if (n_obs !== 4) $display("FAIL ign_count got %0d want 4", n_obs); else n_pass++;
    n_checks++; if (done_cyc !== 9 || done_cnt !== 1) $display("FAIL ign_done got cycle %0d pulses %0d want 9 1", done_cyc, done_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_idx[k] !== 4'd3 || obs_out[k] !== k[0]) $display("FAIL ign_branch[%0d] got %0h/%0h want 3/%0h", k, obs_idx[k], obs_out[k], k[0]); else n_pass++;
    end
    n_checks++; if (bus.miss_cnt !== 16'd2) $display("FAIL ign_miss got %0d want 2", bus.miss_cnt); else n_pass++;
    run(2, 1, 0);
    n_checks++; if (n_obs !== 2 || obs_idx[0] !== 4'd3 || obs_out[0] !== 1'b0) $display("FAIL ign_table_kept got %0d %0h/%0h want 2 3/0", n_obs, obs_idx[0], obs_out[0]); else n_pass++;
  endtask

  task automatic test_mid_run_reset;
    int seen;
    bit done_seen;
    write_slot(2'd0, 4'd5, 8'hFF, 3'd0, 1'b0);
    bus.prediction = 1'b1;
    bus.num_branches = 16'd8;
    bus.active_slots = 3'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.branch_valid) seen++;
      if (seen == 3) break;
      tick();
    end
    n_checks++; if (seen !== 3) $display("FAIL rst_third_issue got %0d want 3", seen); else n_pass++;
    n_checks++; if (bus.total_cnt !== 16'd2) $display("FAIL rst_pre_total got %0d want 2", bus.total_cnt); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL rst_busy_done got %0h/%0h want 0/0", bus.busy, bus.done); else n_pass++;
    n_checks++; if (bus.branch_valid !== 1'b0) $display("FAIL rst_valid got %0h want 0", bus.branch_valid); else n_pass++;
    n_checks++; if (bus.branch_index !== 4'd0 || bus.branch_outcome !== 1'b0) $display("FAIL rst_stream got %0h/%0h want 0/0", bus.branch_index, bus.branch_outcome); else n_pass++;
    n_checks++; if (bus.total_cnt !== 16'd0 || bus.miss_cnt !== 16'd0 || bus.last_hit !== 1'b0) $display("FAIL rst_counters got %0h/%0h/%0h want 0/0/0", bus.total_cnt, bus.miss_cnt, bus.last_hit); else n_pass++;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done || bus.busy) done_seen = 1'b1;
      tick();
    end
    n_checks++; if (done_seen !== 1'b0) $display("FAIL rst_no_done got %0h want 0", done_seen); else n_pass++;
    run(1, 1, 0);
    n_checks++; if (n_obs !== 1 || obs_idx[0] !== 4'd0 || obs_out[0] !== 1'b0) $display("FAIL rst_cleared_table got %0d %0h/%0h want 1 0/0", n_obs, obs_idx[0], obs_out[0]); else n_pass++;
    n_checks++; if (bus.total_cnt !== 16'd1 || bus.miss_cnt !== 16'd1) $display("FAIL rst_rerun_counts got %0d/%0d want 1/1", bus.total_cnt, bus.miss_cnt); else n_pass++;
  endtask

`ifdef BSG_LFSR_EN
  task automatic test_lfsr;
    logic [7:0] l;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_slot(2'd0, 4'd6, 8'h00, 3'd0, 1'b1);
    bus.prediction = 1'b0;
    run(8, 1, 0);
    l = 8'hA5;
    n_checks++; if (n_obs !== 8) $display("FAIL lfsr_count got %0d want 8", n_obs); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (obs_out[k] !== l[0]) $display("FAIL lfsr_outcome[%0d] got %0h want %0h", k, obs_out[k], l[0]); else n_pass++;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask
`endif

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_slot = '0;
    bus.cfg_index = '0;
    bus.cfg_pattern = '0;
    bus.cfg_len = '0;
    bus.cfg_rand = 1'b0;
    bus.active_slots = '0;
    bus.num_branches = '0;
    bus.start = 1'b0;
    bus.prediction = 1'b0;
    test_reset();
    test_zero_length();
    test_alternating();
    test_pattern_period();
    test_latency();
    test_ignored_inputs();
    test_mid_run_reset();
`ifdef BSG_LFSR_EN
    test_lfsr();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
